alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Parametrised successor of the ECC core ALU wrapper. Accepts tagged ALU commands through a valid/ready queue and sequences the external modular engines (modfa, montprowrap, montinv), including the Montgomery normalisation pass. Conditional swap is done in-block. Returns one tagged result at a time through a valid/ready response port, with explicit error reporting. Sits between the ECC point-arithmetic controller and the engine instances.

Parameters:
WID, 256, operand/result width (>=256; curve constants zero-extended to WID)
DEPTH, 4, command FIFO entries (power of 2, >=2)
TAGW, 4, command tag width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_vld  in  1  command valid
cmd_rdy  out  1  command FIFO not full
cmd_op  in  3  000 FA, 001 MUL, 010 INV, 011 SWAP, others illegal
cmd_nmod  in  1  0 = field prime P, 1 = group order N
cmd_cin  in  1  FA carry-in
cmd_swapvl  in  1  SWAP select
cmd_a, cmd_b  in  WID  operands
cmd_tag  in  TAGW  command tag
rsp_vld  out  1  response valid
rsp_rdy  in  1  response accepted
rsp_r, rsp_rswap  out  WID  result / second swap result
rsp_tag  out  TAGW  echoed tag
rsp_err  out  1  illegal op (or timeout)
status  out  2  00 idle, 01 busy, 10 result pending, 11 error pending
fa_en, fa_a, fa_b, fa_cin, fa_mod  out  1/WID/WID/1/WID  modfa request
fa_sum, fa_vld  in  WID/1  modfa result
pro_start, pro_a, pro_b, pro_m  out  1/WID/WID/WID  montprowrap request
pro_r, pro_vld  in  WID/1  montprowrap result
inv_en, inv_din, inv_mod  out  1/WID/WID  montinv request
inv_r, inv_vld  in  WID/1  montinv result

Behaviour:
- Reset: FIFO emptied, FSM to IDLE, every output 0, except cmd_rdy=1 and status=00. Reset mid-operation aborts the operation; a later engine vld is ignored.
- FIFO: push on cmd_vld&cmd_rdy; cmd_rdy = !full (no same-cycle bypass when full); pointers wrap modulo DEPTH.
- FSM: IDLE, ISSUE, WAIT, NISSUE, NWAIT, RESP.
  - IDLE and FIFO non-empty: pop the head, latch op, operands, tag, mod, R constant; -> ISSUE.
  - ISSUE:
    - FA: fa_en=1 for one cycle -> WAIT.
    - MUL: pro_start=1 (pro_a=a, pro_b=b) -> WAIT.
    - INV: inv_en=1 -> WAIT.
    - SWAP: r=swapvl?b:a, rswap=swapvl?a:b -> RESP.
    - Illegal op: rsp_err=1, r=rswap=0 -> RESP.
  - WAIT:
    - FA: fa_vld captures fa_sum -> RESP.
    - MUL: pro_vld captures pro_r as tmp -> NISSUE.
    - INV: inv_vld captures inv_r as tmp -> NISSUE.
  - NISSUE: pro_start=1 for one cycle, pro_a=tmp, pro_b=Rc -> NWAIT.
    - Rc=1 for INV.
    - Rc=R2P (1444) for MUL with nmod=0; Rc=R2N for MUL with nmod=1.
  - NWAIT: pro_vld captures pro_r -> RESP.
  - RESP: rsp_vld=1, outputs held stable; on rsp_rdy -> IDLE.
- Single command outstanding. Engine vld outside the matching wait state is ignored.
- fa_mod/inv_mod/pro_m = P when latched nmod=0, N when nmod=1. These and the operand outputs are held stable from ISSUE to response.
- Start/en outputs are single-cycle pulses; never re-asserted within one command.
- Minimum latencies, cmd accept to rsp_vld: SWAP 3 cycles; FA 3 + engine latency.

Optional Feature:
ALU_TIMEOUT_EN:
- Defined: a 16-bit counter runs in WAIT/NWAIT. If it reaches parameter TMO (default 16'hFFFF), go to RESP with rsp_err=1 and r=0. The counter clears on every state entry.
- Undefined: no counter; waiting is unbounded.

Decomposition:
- Package alu_seq_pkg holds:
  - op encodings
  - state encodings
  - 256-bit constants P (2^255-19), N, R2P=1444, R2N
- Sub-module alu_cmd_fifo: parametrised synchronous FIFO (WID*2+TAGW+6 bits wide, DEPTH deep).

Test Plan:
- SWAP a=5, b=9, swapvl=1, tag=3 -> rsp_r=9, rsp_rswap=5, rsp_tag=3, rsp_err=0, rsp_vld 3 cycles after accept.
- MUL a=2, b=3, nmod=0 with bench engine model -> pro_start twice: first (2,3,P), second (model result, 1444, P); rsp_r = second pro_r.
- INV din=7, nmod=1 -> inv_en once with inv_mod=N; then pro_start with pro_b=1; rsp_r = pro_r.
- cmd_op=111, tag=7 -> rsp_err=1, status=11, rsp_r=0, no engine start asserted.
- rsp_rdy held 0, push continuously -> DEPTH+1 (5) commands accepted, then cmd_rdy=0. Releasing rsp_rdy drains them in tag order.
- rst asserted during MUL WAIT, then late pro_vld -> no response, status=00, cmd_rdy=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared encodings and curve constants for the ALU sequencer.
// Constants are 256 bits wide; the top zero-extends them to its operand width.
package alu_seq_pkg;

    localparam int unsigned CW   = 256;
    localparam int unsigned CTLW = 6;

    localparam logic [2:0] OP_FA   = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_INV  = 3'b010;
    localparam logic [2:0] OP_SWAP = 3'b011;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_RES  = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_NISSUE = 3'd3,
        S_NWAIT  = 3'd4,
        S_RESP   = 3'd5
    } state_e;

    typedef struct packed {
        logic [2:0] op;
        logic       nmod;
        logic       cin;
        logic       swapvl;
    } cmd_ctl_t;

    // 2^512 mod m by repeated doubling; evaluated at elaboration only.
    function automatic logic [CW-1:0] mont_r2(input logic [CW-1:0] m);
        logic [CW:0] r;
        r = (CW+1)'(1);
        for (int i = 0; i < 2 * CW; i++) begin
            r = r << 1;
            if (r >= {1'b0, m}) r = r - {1'b0, m};
        end
        return r[CW-1:0];
    endfunction

    localparam logic [CW-1:0] P   = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
    localparam logic [CW-1:0] N   = 256'h10000000_00000000_00000000_00000000_14def9de_a2f79cd6_5812631a_5cf5d3ed;
    localparam logic [CW-1:0] R2P = 256'd1444;
    localparam logic [CW-1:0] R2N = mont_r2(N);

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; rdy and empty are registered flags.
module alu_cmd_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         rdy
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = AW + 1;

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_nxt;
    logic            do_push;
    logic            do_pop;

    assign do_push = push & rdy;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        cnt_nxt = cnt;
        if (do_push && !do_pop) cnt_nxt = cnt + CNTW'(1);
        else if (!do_push && do_pop) cnt_nxt = cnt - CNTW'(1);
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            empty  <= 1'b1;
            rdy    <= 1'b1;
        end else begin
            cnt   <= cnt_nxt;
            empty <= (cnt_nxt == '0);
            rdy   <= (cnt_nxt != CNTW'(DEPTH));
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Tagged ALU command sequencer driving modfa / montprowrap / montinv engines.
// ALU_TIMEOUT_EN adds a wait-state watchdog that returns an error response.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned WID   = 256,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAGW  = 4
`ifdef ALU_TIMEOUT_EN
    ,
    parameter logic [15:0] TMO   = 16'hFFFF
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_vld,
    output logic            cmd_rdy,
    input  logic [2:0]      cmd_op,
    input  logic            cmd_nmod,
    input  logic            cmd_cin,
    input  logic            cmd_swapvl,
    input  logic [WID-1:0]  cmd_a,
    input  logic [WID-1:0]  cmd_b,
    input  logic [TAGW-1:0] cmd_tag,
    output logic            rsp_vld,
    input  logic            rsp_rdy,
    output logic [WID-1:0]  rsp_r,
    output logic [WID-1:0]  rsp_rswap,
    output logic [TAGW-1:0] rsp_tag,
    output logic            rsp_err,
    output logic [1:0]      status,
    output logic            fa_en,
    output logic [WID-1:0]  fa_a,
    output logic [WID-1:0]  fa_b,
    output logic            fa_cin,
    output logic [WID-1:0]  fa_mod,
    input  logic [WID-1:0]  fa_sum,
    input  logic            fa_vld,
    output logic            pro_start,
    output logic [WID-1:0]  pro_a,
    output logic [WID-1:0]  pro_b,
    output logic [WID-1:0]  pro_m,
    input  logic [WID-1:0]  pro_r,
    input  logic            pro_vld,
    output logic            inv_en,
    output logic [WID-1:0]  inv_din,
    output logic [WID-1:0]  inv_mod,
    input  logic [WID-1:0]  inv_r,
    input  logic            inv_vld
);

    localparam int unsigned FW = 2 * WID + TAGW + CTLW;

    state_e          state;
    logic [FW-1:0]   fifo_din;
    logic [FW-1:0]   fifo_dout;
    logic            fifo_empty;
    logic            fifo_pop;
    cmd_ctl_t        h_ctl;
    logic [WID-1:0]  h_a;
    logic [WID-1:0]  h_b;
    logic [TAGW-1:0] h_tag;
    logic [WID-1:0]  h_mod;
    logic [WID-1:0]  h_rc;
    logic [2:0]      op_q;
    logic            swapvl_q;
    logic [WID-1:0]  a_q;
    logic [WID-1:0]  b_q;
    logic [WID-1:0]  rc_q;

    assign fifo_din = {cmd_tag, cmd_b, cmd_a, cmd_op, cmd_nmod, cmd_cin, cmd_swapvl};
    assign {h_tag, h_b, h_a, h_ctl} = fifo_dout;
    assign fifo_pop = (state == S_IDLE) && !fifo_empty;

    // Modulus and normalisation constant selected from the head entry at pop.
    assign h_mod = h_ctl.nmod ? WID'(N) : WID'(P);
    assign h_rc  = (h_ctl.op == OP_INV) ? WID'(1) : (h_ctl.nmod ? WID'(R2N) : WID'(R2P));

    alu_cmd_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_vld),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .rdy   (cmd_rdy)
    );

`ifdef ALU_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO);

    // Zero on entry to each wait state; counts only while waiting.
    always_ff @(posedge clk) begin
        if (rst) tmo_cnt <= '0;
        else if (state == S_WAIT || state == S_NWAIT) tmo_cnt <= tmo_cnt + 16'd1;
        else tmo_cnt <= '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= '0;
            swapvl_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            rc_q      <= '0;
            rsp_vld   <= 1'b0;
            rsp_r     <= '0;
            rsp_rswap <= '0;
            rsp_tag   <= '0;
            rsp_err   <= 1'b0;
            status    <= ST_IDLE;
            fa_en     <= 1'b0;
            fa_a      <= '0;
            fa_b      <= '0;
            fa_cin    <= 1'b0;
            fa_mod    <= '0;
            pro_start <= 1'b0;
            pro_a     <= '0;
            pro_b     <= '0;
            pro_m     <= '0;
            inv_en    <= 1'b0;
            inv_din   <= '0;
            inv_mod   <= '0;
        end else begin
            fa_en     <= 1'b0;
            pro_start <= 1'b0;
            inv_en    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        op_q      <= h_ctl.op;
                        swapvl_q  <= h_ctl.swapvl;
                        a_q       <= h_a;
                        b_q       <= h_b;
                        rc_q      <= h_rc;
                        rsp_tag   <= h_tag;
                        rsp_err   <= 1'b0;
                        rsp_r     <= '0;
                        rsp_rswap <= '0;
                        status    <= ST_BUSY;
                        state     <= S_ISSUE;
                        // Request pulses go out during the ISSUE cycle.
                        case (h_ctl.op)
                            OP_FA: begin
                                fa_en  <= 1'b1;
                                fa_a   <= h_a;
                                fa_b   <= h_b;
                                fa_cin <= h_ctl.cin;
                                fa_mod <= h_mod;
                            end
                            OP_MUL: begin
                                pro_start <= 1'b1;
                                pro_a     <= h_a;
                                pro_b     <= h_b;
                                pro_m     <= h_mod;
                            end
                            OP_INV: begin
                                inv_en  <= 1'b1;
                                inv_din <= h_a;
                                inv_mod <= h_mod;
                                pro_m   <= h_mod;
                            end
                            default: ;
                        endcase
                    end
                end
                S_ISSUE: begin
                    case (op_q)
                        OP_FA, OP_MUL, OP_INV: state <= S_WAIT;
                        OP_SWAP: begin
                            rsp_r     <= swapvl_q ? b_q : a_q;
                            rsp_rswap <= swapvl_q ? a_q : b_q;
                            rsp_vld   <= 1'b1;
                            status    <= ST_RES;
                            state     <= S_RESP;
                        end
                        default: begin
                            rsp_err <= 1'b1;
                            rsp_vld <= 1'b1;
                            status  <= ST_ERR;
                            state   <= S_RESP;
                        end
                    endcase
                end
                S_WAIT: begin
                    case (op_q)
                        OP_FA: if (fa_vld) begin
                            rsp_r   <= fa_sum;
                            rsp_vld <= 1'b1;
                            status  <= ST_RES;
                            state   <= S_RESP;
                        end
                        OP_MUL: if (pro_vld) begin
                            pro_start <= 1'b1;
                            pro_a     <= pro_r;
                            pro_b     <= rc_q;
                            state     <= S_NISSUE;
                        end
                        OP_INV: if (inv_vld) begin
                            pro_start <= 1'b1;
                            pro_a     <= inv_r;
                            pro_b     <= rc_q;
                            state     <= S_NISSUE;
                        end
                        default: ;
                    endcase
`ifdef ALU_TIMEOUT_EN
                    if (tmo_hit) begin
                        pro_start <= 1'b0;
                        rsp_r     <= '0;
                        rsp_err   <= 1'b1;
                        rsp_vld   <= 1'b1;
                        status    <= ST_ERR;
                        state     <= S_RESP;
                    end
`endif
                end
                S_NISSUE: state <= S_NWAIT;
                S_NWAIT: begin
                    if (pro_vld) begin
                        rsp_r   <= pro_r;
                        rsp_vld <= 1'b1;
                        status  <= ST_RES;
                        state   <= S_RESP;
                    end
`ifdef ALU_TIMEOUT_EN
                    if (tmo_hit) begin
                        rsp_r   <= '0;
                        rsp_err <= 1'b1;
                        rsp_vld <= 1'b1;
                        status  <= ST_ERR;
                        state   <= S_RESP;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        status  <= ST_IDLE;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with small behavioural engine models.
module tb_alu_seq_ctrl;

    localparam int unsigned WID   = 256;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAGW  = 4;

    localparam logic [WID-1:0] P_C = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
    localparam logic [WID-1:0] N_C = 256'h10000000_00000000_00000000_00000000_14def9de_a2f79cd6_5812631a_5cf5d3ed;

    typedef struct {
        logic [WID-1:0]  r;
        logic [WID-1:0]  rswap;
        logic [TAGW-1:0] tag;
        logic            err;
    } rsp_t;

    typedef struct {
        logic [WID-1:0] a;
        logic [WID-1:0] b;
        logic [WID-1:0] m;
        logic           cin;
    } req_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_vld, cmd_rdy;
    logic [2:0]      cmd_op;
    logic            cmd_nmod, cmd_cin, cmd_swapvl;
    logic [WID-1:0]  cmd_a, cmd_b;
    logic [TAGW-1:0] cmd_tag;
    logic            rsp_vld, rsp_rdy;
    logic [WID-1:0]  rsp_r, rsp_rswap;
    logic [TAGW-1:0] rsp_tag;
    logic            rsp_err;
    logic [1:0]      status;
    logic            fa_en, fa_cin, fa_vld;
    logic [WID-1:0]  fa_a, fa_b, fa_mod, fa_sum;
    logic            pro_start, pro_vld;
    logic [WID-1:0]  pro_a, pro_b, pro_m, pro_r;
    logic            inv_en, inv_vld;
    logic [WID-1:0]  inv_din, inv_mod, inv_r;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int fa_lat = 1, pro_lat = 2, inv_lat = 3;
    int fa_cnt = 0, pro_cnt = 0, inv_cnt = 0;
    logic [WID-1:0] fa_res, pro_res, inv_res;

    rsp_t exp_rsp[$];
    req_t exp_fa[$];
    req_t exp_pro[$];
    req_t exp_inv[$];

    alu_seq_ctrl #(.WID(WID), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_nmod(cmd_nmod),
        .cmd_cin(cmd_cin), .cmd_swapvl(cmd_swapvl), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_tag(cmd_tag),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_r(rsp_r), .rsp_rswap(rsp_rswap),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .status(status),
        .fa_en(fa_en), .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_mod(fa_mod),
        .fa_sum(fa_sum), .fa_vld(fa_vld),
        .pro_start(pro_start), .pro_a(pro_a), .pro_b(pro_b), .pro_m(pro_m),
        .pro_r(pro_r), .pro_vld(pro_vld),
        .inv_en(inv_en), .inv_din(inv_din), .inv_mod(inv_mod),
        .inv_r(inv_r), .inv_vld(inv_vld)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [WID-1:0] act, input logic [WID-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event with nothing expected", name);
    endtask

    task automatic exp_r(input logic [WID-1:0] r, input logic [WID-1:0] rs,
                         input logic [TAGW-1:0] t, input logic e);
        rsp_t x;
        x.r = r; x.rswap = rs; x.tag = t; x.err = e;
        exp_rsp.push_back(x);
    endtask

    function automatic req_t mk_req(input logic [WID-1:0] a, input logic [WID-1:0] b,
                                    input logic [WID-1:0] m, input logic cin);
        req_t x;
        x.a = a; x.b = b; x.m = m; x.cin = cin;
        return x;
    endfunction

    // Engine models: fixed latency, simple deterministic arithmetic.
    always begin
        @(posedge clk); #1;
        fa_vld = 1'b0; pro_vld = 1'b0; inv_vld = 1'b0;
        if (fa_cnt > 0) begin fa_cnt--; if (fa_cnt == 0) begin fa_vld = 1'b1; fa_sum = fa_res; end end
        if (pro_cnt > 0) begin pro_cnt--; if (pro_cnt == 0) begin pro_vld = 1'b1; pro_r = pro_res; end end
        if (inv_cnt > 0) begin inv_cnt--; if (inv_cnt == 0) begin inv_vld = 1'b1; inv_r = inv_res; end end
        if (fa_en)     begin fa_cnt = fa_lat;   fa_res  = fa_a + fa_b + WID'(fa_cin); end
        if (pro_start) begin pro_cnt = pro_lat; pro_res = pro_a * pro_b + WID'(17); end
        if (inv_en)    begin inv_cnt = inv_lat; inv_res = inv_din + WID'(100); end
    end

    // Monitor: responses and engine requests against the scoreboard queues.
    always @(negedge clk) begin
        rsp_t e;
        req_t q;
        if (!rst) begin
            if (rsp_vld && rsp_rdy) begin
                if (exp_rsp.size() == 0) unexpected("rsp");
                else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_r", rsp_r, e.r);
                    chk("rsp_rswap", rsp_rswap, e.rswap);
                    chk("rsp_tag", WID'(rsp_tag), WID'(e.tag));
                    chk("rsp_err", WID'(rsp_err), WID'(e.err));
                end
            end
            if (fa_en) begin
                if (exp_fa.size() == 0) unexpected("fa_en");
                else begin
                    q = exp_fa.pop_front();
                    chk("fa_a", fa_a, q.a);
                    chk("fa_b", fa_b, q.b);
                    chk("fa_mod", fa_mod, q.m);
                    chk("fa_cin", WID'(fa_cin), WID'(q.cin));
                end
            end
            if (pro_start) begin
                if (exp_pro.size() == 0) unexpected("pro_start");
                else begin
                    q = exp_pro.pop_front();
                    chk("pro_a", pro_a, q.a);
                    chk("pro_b", pro_b, q.b);
                    chk("pro_m", pro_m, q.m);
                end
            end
            if (inv_en) begin
                if (exp_inv.size() == 0) unexpected("inv_en");
                else begin
                    q = exp_inv.pop_front();
                    chk("inv_din", inv_din, q.a);
                    chk("inv_mod", inv_mod, q.m);
                end
            end
        end
    end

    task automatic set_cmd(input logic [2:0] op, input logic nmod, input logic cin, input logic sv,
                           input logic [WID-1:0] a, input logic [WID-1:0] b, input logic [TAGW-1:0] tag);
        cmd_op = op; cmd_nmod = nmod; cmd_cin = cin; cmd_swapvl = sv;
        cmd_a = a; cmd_b = b; cmd_tag = tag;
    endtask

    task automatic send(input logic [2:0] op, input logic nmod, input logic cin, input logic sv,
                        input logic [WID-1:0] a, input logic [WID-1:0] b, input logic [TAGW-1:0] tag,
                        output int acc);
        int n = 0;
        @(posedge clk); #1;
        set_cmd(op, nmod, cin, sv, a, b, tag);
        cmd_vld = 1'b1;
        while (!cmd_rdy && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) unexpected("cmd_rdy_timeout");
        acc = cyc;
        @(posedge clk); #1;
        cmd_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_rsp.size() == 0 && status == 2'b00 && !rsp_vld) && n < 400) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 400) unexpected("idle_timeout");
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_vld && n < 100) begin @(negedge clk); n++; end
    endtask

    initial begin
        int acc;
        int accepted;
        logic [TAGW-1:0] t;
        rst = 1'b1; cmd_vld = 1'b0; rsp_rdy = 1'b1;
        set_cmd(3'b000, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_rdy", WID'(cmd_rdy), WID'(1));
        chk("reset_status", WID'(status), WID'(0));
        chk("reset_rsp_vld", WID'(rsp_vld), WID'(0));
        chk("reset_rsp_r", rsp_r, '0);
        chk("reset_rsp_err", WID'(rsp_err), WID'(0));
        chk("reset_pulses", WID'({fa_en, pro_start, inv_en}), WID'(0));
        chk("reset_pro_m", pro_m, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // SWAP with swapvl=1, latency and status during response
        exp_r(WID'(9), WID'(5), TAGW'(3), 1'b0);
        send(3'b011, 1'b0, 1'b0, 1'b1, WID'(5), WID'(9), TAGW'(3), acc);
        wait_rsp();
        chk("swap_latency", WID'(cyc - acc), WID'(3));
        chk("swap_status", WID'(status), WID'(2));
        wait_idle();

        // MUL (2,3) modulo P: product then normalisation by 1444
        exp_pro.push_back(mk_req(WID'(2), WID'(3), P_C, 1'b0));
        exp_pro.push_back(mk_req(WID'(23), WID'(1444), P_C, 1'b0));
        exp_r(WID'(33229), '0, TAGW'(4), 1'b0);
        send(3'b001, 1'b0, 1'b0, 1'b0, WID'(2), WID'(3), TAGW'(4), acc);
        wait_idle();

        // INV 7 modulo N: inverse then normalisation by 1
        exp_inv.push_back(mk_req(WID'(7), '0, N_C, 1'b0));
        exp_pro.push_back(mk_req(WID'(107), WID'(1), N_C, 1'b0));
        exp_r(WID'(124), '0, TAGW'(5), 1'b0);
        send(3'b010, 1'b1, 1'b0, 1'b0, WID'(7), '0, TAGW'(5), acc);
        wait_idle();

        // FA 10+20+cin modulo P, latency 3 + engine latency
        exp_fa.push_back(mk_req(WID'(10), WID'(20), P_C, 1'b1));
        exp_r(WID'(31), '0, TAGW'(6), 1'b0);
        send(3'b000, 1'b0, 1'b1, 1'b0, WID'(10), WID'(20), TAGW'(6), acc);
        wait_rsp();
        chk("fa_latency", WID'(cyc - acc), WID'(3 + fa_lat));
        wait_idle();

        // Illegal op: error response, zero results, no engine activity
        rsp_rdy = 1'b0;
        exp_r('0, '0, TAGW'(7), 1'b1);
        send(3'b111, 1'b0, 1'b0, 1'b0, WID'(170), WID'(187), TAGW'(7), acc);
        wait_rsp();
        chk("illegal_status", WID'(status), WID'(3));
        @(posedge clk); #1;
        rsp_rdy = 1'b1;
        wait_idle();

        // SWAP with swapvl=0 passes operands straight through
        exp_r(WID'(1), WID'(2), TAGW'(8), 1'b0);
        send(3'b011, 1'b0, 1'b0, 1'b0, WID'(1), WID'(2), TAGW'(8), acc);
        wait_idle();

        // Backpressure: one command in flight plus DEPTH queued
        rsp_rdy = 1'b0;
        accepted = 0;
        t = TAGW'(9);
        @(posedge clk); #1;
        set_cmd(3'b011, 1'b0, 1'b0, 1'b0, WID'(t), WID'(t) + WID'(100), t);
        cmd_vld = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic acc_now;
            acc_now = cmd_rdy;
            if (acc_now) begin
                exp_r(WID'(t), WID'(t) + WID'(100), t, 1'b0);
                accepted++;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                t = t + TAGW'(1);
                set_cmd(3'b011, 1'b0, 1'b0, 1'b0, WID'(t), WID'(t) + WID'(100), t);
            end
        end
        cmd_vld = 1'b0;
        chk("bp_accepted", WID'(accepted), WID'(DEPTH + 1));
        chk("bp_cmd_rdy", WID'(cmd_rdy), WID'(0));
        rsp_rdy = 1'b1;
        wait_idle();

        // Reset during MUL wait; the late engine result must be ignored
        pro_lat = 20;
        exp_pro.push_back(mk_req(WID'(4), WID'(5), P_C, 1'b0));
        send(3'b001, 1'b0, 1'b0, 1'b0, WID'(4), WID'(5), TAGW'(2), acc);
        repeat (4) @(posedge clk);
        #1;
        chk("mul_busy", WID'(status), WID'(1));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("abort_status", WID'(status), WID'(0));
        chk("abort_cmd_rdy", WID'(cmd_rdy), WID'(1));
        chk("abort_rsp_vld", WID'(rsp_vld), WID'(0));
        pro_lat = 2;

        chk("rsp_queue_empty", WID'(exp_rsp.size()), '0);
        chk("fa_queue_empty", WID'(exp_fa.size()), '0);
        chk("pro_queue_empty", WID'(exp_pro.size()), '0);
        chk("inv_queue_empty", WID'(exp_inv.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
